// File: rtl/izh_pkg.sv
// Shared Q8.8 fixed-point types and a saturation helper for the Izhikevich datapath.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package izh_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam q8_8_t Q_MAX = 16'sh7FFF;
  localparam q8_8_t Q_MIN = 16'sh8000;

  // Widest accumulator any caller needs: 16-bit weights, up to 32 synapses
  // (5 growth bits) plus 2 bits for the decayed current and the bias.
  localparam int ACC_MAX_W = 16 + 5 + 2;

  typedef struct packed {
    q8_8_t val;
    logic  clip;
  } sat_res_t;

  // Callers sign-extend their accumulator to ACC_MAX_W before calling.
  function automatic sat_res_t sat_q8_8(input logic signed [ACC_MAX_W-1:0] wide);
    sat_res_t r;
    if (wide > ACC_MAX_W'(Q_MAX)) begin
      r.val  = Q_MAX;
      r.clip = 1'b1;
    end else if (wide < ACC_MAX_W'(Q_MIN)) begin
      r.val  = Q_MIN;
      r.clip = 1'b1;
    end else begin
      r.val  = wide[15:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/izh_weight_sum.sv
// Masked adder: sums the weights whose spike bit is set, signed, without saturation.
// Latency: combinational; the result is registered by the caller.
// Backpressure: none; ports: weights (N_SYN x Q8.8), mask (spike vector), sum (SUM_W bits).
module izh_weight_sum
  import izh_pkg::*;
#(
  parameter int N_SYN = 8,
  parameter int SUM_W = 16 + $clog2(N_SYN)
) (
  input  q8_8_t [N_SYN-1:0]        weights,
  input  logic  [N_SYN-1:0]        mask,
  output logic signed [SUM_W-1:0]  sum
);

  always_comb begin
    q8_8_t w_i;
    sum = '0;
    w_i = '0;
    for (int i = 0; i < N_SYN; i++) begin
      w_i = weights[i];
      if (mask[i]) begin
        sum = sum + SUM_W'(w_i);
      end
    end
  end

endmodule

// File: rtl/izh_synapse_current.sv
// Synaptic current generator: spikes add programmable weights, current decays by I>>>TAU_SHIFT.
// Latency: 2 cycles spike-to-I_syn (stage 1 weight sum, stage 2 decay/accumulate/clip).
// Backpressure: none; en=0 freezes both stages and drops spikes. Optional I_bias with SYN_BIAS_EN.
//
// Ports: clk, rst (async active-low), en, pre_spike[N_SYN], w_we/w_addr/w_data (weight write),
//        I_bias (only when SYN_BIAS_EN is defined), I_syn (Q8.8 out), sat (clip pulse).
module izh_synapse_current
  import izh_pkg::*;
#(
  parameter int N_SYN     = 8,
  parameter int TAU_SHIFT = 4,
  localparam int AW       = $clog2(N_SYN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SYN-1:0] pre_spike,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [15:0]      w_data,
`ifdef SYN_BIAS_EN
  input  q8_8_t            I_bias,
`endif
  output q8_8_t            I_syn,
  output logic             sat
);

  localparam int SUM_W = 16 + AW;
  localparam int ACC_W = SUM_W + 2;

  // Weight file
  q8_8_t [N_SYN-1:0] w_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
    end else if (w_we) begin
      w_q[w_addr] <= w_data;
    end
  end

  // Stage 1: masked sum, registered. Reads w_q before this edge's write lands,
  // so a same-cycle write and spike on one index uses the old weight.
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;

  izh_weight_sum #(
    .N_SYN (N_SYN),
    .SUM_W (SUM_W)
  ) u_weight_sum (
    .weights (w_q),
    .mask    (pre_spike),
    .sum     (sum_d)
  );

  // Stage 2: decay, accumulate, clip
  logic signed [ACC_W-1:0]     i_ext;
  logic signed [ACC_W-1:0]     bias_ext;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_MAX_W-1:0] acc_wide;
  sat_res_t                    res;

  always_comb begin
    i_ext = ACC_W'(I_syn);
`ifdef SYN_BIAS_EN
    bias_ext = ACC_W'(I_bias);
`else
    bias_ext = '0;
`endif
    // >>> floors, so small positive residues stick and negatives settle at 0 or -1.
    acc      = i_ext - (i_ext >>> TAU_SHIFT) + ACC_W'(sum_q) + bias_ext;
    acc_wide = ACC_MAX_W'(acc);
    res      = sat_q8_8(acc_wide);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      I_syn <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      sum_q <= sum_d;
      I_syn <= res.val;
      sat   <= res.clip;
    end else begin
      sat   <= 1'b0;
    end
  end

endmodule
